// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch stage and the Decode stage.
//   INSTR_W           instruction word width
//   OPC_MSB/OPC_LSB   opcode field position inside an instruction word
//   OPC_HALT          opcode that stops fetching
//   fetch_state_t     fetch FSM states (encodings fixed for legacy compatibility)
//   is_halt()         opcode-field test shared by fetch and decode
package fetch_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam logic [3:0]  OPC_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch -> decode instruction stream.
//   instruction  word at the prefetch buffer head
//   instr_pc     address of that word
//   instr_valid  head is valid
//   instr_ready  consumer accepts the head this cycle
// modport master = fetch side, modport slave = decode side.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [fetch_pkg::INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]             instr_pc;
  logic                          instr_valid;
  logic                          instr_ready;

  modport master (output instruction, output instr_pc, output instr_valid, input instr_ready);
  modport slave  (input instruction, input instr_pc, input instr_valid, output instr_ready);
endinterface

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: 2-entry prefetch buffer holding {data, pc} per entry.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, pop_i      write new entry / retire head (same cycle allowed)
//   flush_i            synchronous empty, wins over push/pop
//   data_i, pc_i       entry to push
//   data_o, pc_o       head entry, valid_o when count_o != 0
//   count_o            occupancy 0..2
module fetch_fifo2
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] data_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o,
  output logic [1:0]         count_o
);

  logic [INSTR_W-1:0] hd_data_q, hd_data_d, tl_data_q, tl_data_d;
  logic [ADDR_W-1:0]  hd_pc_q, hd_pc_d, tl_pc_q, tl_pc_d;
  logic [1:0]         count_q, count_d;
  logic               push, pop;

  assign pop  = pop_i && (count_q != 2'd0);
  assign push = push_i && ((count_q != 2'd2) || pop);

  // Head register is always the oldest entry; a pop shifts tail into head.
  always_comb begin
    hd_data_d = hd_data_q;
    hd_pc_d   = hd_pc_q;
    tl_data_d = tl_data_q;
    tl_pc_d   = tl_pc_q;
    count_d   = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            hd_data_d = data_i;
            hd_pc_d   = pc_i;
          end else begin
            tl_data_d = data_i;
            tl_pc_d   = pc_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          hd_data_d = tl_data_q;
          hd_pc_d   = tl_pc_q;
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            hd_data_d = data_i;
            hd_pc_d   = pc_i;
          end else begin
            hd_data_d = tl_data_q;
            hd_pc_d   = tl_pc_q;
            tl_data_d = data_i;
            tl_pc_d   = pc_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hd_data_q <= '0;
      hd_pc_q   <= '0;
      tl_data_q <= '0;
      tl_pc_q   <= '0;
      count_q   <= '0;
    end else begin
      hd_data_q <= hd_data_d;
      hd_pc_q   <= hd_pc_d;
      tl_data_q <= tl_data_d;
      tl_pc_q   <= tl_pc_d;
      count_q   <= count_d;
    end
  end

  assign data_o  = hd_data_q;
  assign pc_o    = hd_pc_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: loadable program store, PC walker and fetch FSM feeding
// a 2-entry prefetch buffer toward Decode.
//   clk, rst (async, active-low), start, flush
//   ld_en/ld_addr/ld_data  program-store write port (IDLE/DONE only)
//   fetch_if (master)      instruction/instr_pc/instr_valid/instr_ready stream
//   busy (RUN or DRAIN), done (DONE)
// Build option: FETCH_LOOP_EN -- PC wraps after the last word instead of
// ending the run; only HALT or flush then stops fetching.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter  int unsigned PROG_DEPTH = 16,
  localparam int unsigned ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      flush,
  input  logic                      ld_en,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [INSTR_W-1:0]        ld_data,
  instr_fetch_unit_if.master        fetch_if,
  output logic                      busy,
  output logic                      done
);

`ifdef FETCH_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] mem_q [PROG_DEPTH];
  logic [INSTR_W-1:0] fetch_word;
  logic [1:0]         count;
  logic               push, pop, last_pc;

  assign fetch_word = mem_q[pc_q];
  assign pop        = fetch_if.instr_valid & fetch_if.instr_ready;
  assign last_pc    = (pc_q == ADDR_W'(PROG_DEPTH - 1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            pc_d    = '0;
          end
        end
        RUN: begin
          if ((count != 2'd2) || pop) begin
            push = 1'b1;
            pc_d = pc_q + 1'b1;
            if (is_halt(fetch_word) || (!LOOP_EN && last_pc)) state_d = DRAIN;
          end
        end
        // Uses registered occupancy, so DONE follows the final pop by a cycle.
        DRAIN: if (count == 2'd0) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Program store is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (ld_en && ((state_q == IDLE) || (state_q == DONE))) mem_q[ld_addr] <= ld_data;
  end

  fetch_fifo2 #(.ADDR_W(ADDR_W)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (fetch_word),
    .pc_i    (pc_q),
    .data_o  (fetch_if.instruction),
    .pc_o    (fetch_if.instr_pc),
    .valid_o (fetch_if.instr_valid),
    .count_o (count)
  );

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
`ifdef FETCH_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, flush, ld_en;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_data;
  logic          busy, done;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW)) fif ();

  instr_fetch_unit #(.PROG_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .fetch_if (fif),
    .busy     (busy),
    .done     (done)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0]   w;
    logic [AW-1:0] pc;
  } exp_t;
  exp_t        expq[$];
  logic [15:0] model_mem[DEPTH];

  typedef struct {
    bit          rdy;
    bit          chk_d;
    bit          v;
    logic [15:0] ins;
    logic [3:0]  pc;
    bit          b;
    bit          d;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s bound expired", name);
  endtask

  // Expected delivery order from the store: addresses 0,1,2,... until a HALT
  // word (inclusive) or, without looping, the last address.
  function automatic void build_expected();
    int unsigned a;
    expq.delete();
    for (int unsigned n = 0; n < 40; n++) begin
      a = n % DEPTH;
      expq.push_back('{model_mem[a], AW'(a)});
      if (model_mem[a][15:12] == 4'hF) break;
      if (!LOOP && a == DEPTH - 1) break;
    end
  endfunction

  task automatic load(input int unsigned addr, input logic [15:0] data, input bit legal);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = AW'(addr); ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    if (legal) model_mem[addr] = data;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_table(input int lo, input int hi);
    pulse_start();
    for (int i = lo; i <= hi; i++) begin
      chk($sformatf("tbl%0d_valid", i), 32'(fif.instr_valid), 32'(vt[i].v));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].b));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(vt[i].d));
      if (vt[i].chk_d) begin
        chk($sformatf("tbl%0d_instr", i), 32'(fif.instruction), 32'(vt[i].ins));
        chk($sformatf("tbl%0d_pc", i), 32'(fif.instr_pc), 32'(vt[i].pc));
      end
      if (lo == 7 && i == lo + 4) chk("pc_hold_at_2", 32'(dut.pc_q), 32'd2);
      fif.instr_ready = vt[i].rdy;
      @(negedge clk);
    end
    fif.instr_ready = 1'b0;
  endtask

  // Runs from PC 0 with random backpressure; every visible head must equal
  // the model's next expected word. limit != 0 stops after that many pops.
  task automatic run_collect(input int unsigned pct, input int unsigned limit, input string tag);
    int unsigned pops = 0;
    int unsigned cyc  = 0;
    bit r;
    build_expected();
    pulse_start();
    while (1) begin
      if (done) break;
      if (cyc > 400) begin fail_now({tag, "_timeout"}); break; end
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      r = ($urandom_range(99) < pct);
      if (fif.instr_valid) begin
        if (expq.size() == 0) begin
          fail_now({tag, "_extra_word"});
        end else begin
          chk({tag, "_instr"}, 32'(fif.instruction), 32'(expq[0].w));
          chk({tag, "_pc"}, 32'(fif.instr_pc), 32'(expq[0].pc));
          if (r) begin
            void'(expq.pop_front());
            pops++;
          end
        end
      end
      fif.instr_ready = r;
      if (limit != 0 && pops >= limit) break;
      @(negedge clk);
      cyc++;
    end
    fif.instr_ready = 1'b0;
    if (limit == 0) begin
      chk({tag, "_remaining"}, 32'(expq.size()), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // {rdy, chk_d, valid, instr, pc, busy, done}; ready-high stream
    vt[0]  = '{1, 0, 0, 16'h0000, 4'd0, 1, 0};
    vt[1]  = '{1, 1, 1, 16'h1123, 4'd0, 1, 0};
    vt[2]  = '{1, 1, 1, 16'h2045, 4'd1, 1, 0};
    vt[3]  = '{1, 1, 1, 16'h3001, 4'd2, 1, 0};
    vt[4]  = '{1, 1, 1, 16'hF000, 4'd3, 1, 0};
    vt[5]  = '{1, 0, 0, 16'h0000, 4'd0, 1, 0};
    vt[6]  = '{1, 0, 0, 16'h0000, 4'd0, 0, 1};
    // ready held low for 5 cycles, then released
    vt[7]  = '{0, 0, 0, 16'h0000, 4'd0, 1, 0};
    vt[8]  = '{0, 1, 1, 16'h1123, 4'd0, 1, 0};
    vt[9]  = '{0, 1, 1, 16'h1123, 4'd0, 1, 0};
    vt[10] = '{0, 1, 1, 16'h1123, 4'd0, 1, 0};
    vt[11] = '{0, 1, 1, 16'h1123, 4'd0, 1, 0};
    vt[12] = '{1, 1, 1, 16'h1123, 4'd0, 1, 0};
    vt[13] = '{1, 1, 1, 16'h2045, 4'd1, 1, 0};
    vt[14] = '{1, 1, 1, 16'h3001, 4'd2, 1, 0};
    vt[15] = '{1, 1, 1, 16'hF000, 4'd3, 1, 0};
    vt[16] = '{1, 0, 0, 16'h0000, 4'd0, 1, 0};
    vt[17] = '{0, 0, 0, 16'h0000, 4'd0, 0, 1};

    for (int unsigned i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    rst = 1'b0; start = 1'b0; flush = 1'b0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0; fif.instr_ready = 1'b0;

    #3;
    chk("reset_valid", 32'(fif.instr_valid), 32'd0);
    chk("reset_instr", 32'(fif.instruction), 32'd0);
    chk("reset_pc", 32'(fif.instr_pc), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    load(0, 16'h1123, 1); load(1, 16'h2045, 1);
    load(2, 16'h3001, 1); load(3, 16'hF000, 1);
    run_table(0, 6);
    run_table(7, 17);

    // Write during RUN is ignored
    fif.instr_ready = 1'b0;
    pulse_start();
    load(2, 16'hAAAA, 0);
    fif.instr_ready = 1'b1;
    for (int c = 0; c < 50 && !done; c++) @(negedge clk);
    fif.instr_ready = 1'b0;
    chk("ld_run_reached_done", 32'(done), 32'd1);
    run_collect(100, 0, "after_run_ld");

    // Write during DONE takes effect
    load(2, 16'hAAAA, 1);
    run_collect(70, 0, "after_done_ld");

    // flush + start together in DONE
    @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("fs_done", 32'(done), 32'd0);
    chk("fs_busy", 32'(busy), 32'd0);
    chk("fs_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk); @(negedge clk);
    chk("fs_valid_later", 32'(fif.instr_valid), 32'd0);
    chk("fs_busy_later", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN with a valid head
    load(2, 16'h3001, 1);
    pulse_start();
    @(negedge clk); @(negedge clk);
    chk("pre_rst_valid", 32'(fif.instr_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(fif.instr_valid), 32'd0);
    chk("arst_instr", 32'(fif.instruction), 32'd0);
    chk("arst_pc", 32'(fif.instr_pc), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    run_collect(100, 0, "after_arst");

    // Full store, no HALT
    for (int unsigned a = 0; a < DEPTH; a++)
      load(a, {4'($urandom_range(14)), 12'($urandom)}, 1);
    if (LOOP) begin
      run_collect(100, DEPTH + 1, "full_loop");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("loop_flush_valid", 32'(fif.instr_valid), 32'd0);
      chk("loop_flush_busy", 32'(busy), 32'd0);
    end else begin
      run_collect(100, 0, "full_noloop");
    end

    // Random programs with random backpressure
    for (int it = 0; it < 20; it++) begin
      for (int unsigned a = 0; a < DEPTH; a++)
        load(a, {4'($urandom_range(14)), 12'($urandom)}, 1);
      if (LOOP || $urandom_range(1) == 1)
        load($urandom_range(DEPTH - 1), {4'hF, 12'($urandom)}, 1);
      run_collect($urandom_range(100, 30), 0, $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-memory and fetch stage that sits directly upstream of the CPU's Decode/Execute path. It holds a loadable instruction store and walks a program counter. Fetched 16-bit words go through a 2-entry prefetch buffer, which presents them downstream with a valid/ready handshake. Fetch stops on a HALT opcode or at the end of the program store.

## Interface
Parameters:
- PROG_DEPTH, 16: number of 16-bit instruction words; a power of two, at least 4.
- ADDR_W, $clog2(PROG_DEPTH): PC and load-address width. Derived; not overridden.

Ports:
- clk  in  1  single system clock; everything is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a run from PC 0 when the state is IDLE or DONE.
- flush  in  1  synchronous abort: empties the buffer and returns the state to IDLE.
- ld_en  in  1  program-store write strobe.
- ld_addr  in  ADDR_W  write address.
- ld_data  in  16  write data.
- instruction  out  16  word at the buffer head.
- instr_pc  out  ADDR_W  address of the word at the buffer head.
- instr_valid  out  1  buffer head is valid.
- instr_ready  in  1  downstream accepts the head this cycle.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE -> RUN when start is high. PC is loaded with 0 and the buffer is already empty.
- RUN: a push occurs each cycle that count < 2, or count == 2 with a pop in the same cycle.
  - A push writes {mem[pc], pc} into the buffer and sets pc <= pc+1.
  - Memory read is combinational.
- Pushed word with opcode instruction[15:12] == 4'hF (HALT): RUN -> DRAIN. The HALT word is itself delivered downstream.
- Push from pc == PROG_DEPTH-1 with no HALT: the behaviour depends on the configuration (see Configuration).
- DRAIN: no pushes. DRAIN -> DONE when count reaches 0.
- DONE: done = 1. start re-enters RUN from PC 0.
- A pop occurs when instr_valid and instr_ready are both high. Push and pop in the same cycle leave count unchanged.
- flush overrides everything else in its cycle: count <= 0, pc <= 0, state <= IDLE. A start in the same cycle is ignored.
- ld_en writes only in IDLE or DONE. It is ignored in RUN or DRAIN, and the store is left unchanged.
- Program-store contents are not affected by rst.
- start in RUN or DRAIN is ignored.

## Timing
- Reset values: instruction = 0, instr_pc = 0, instr_valid = 0, busy = 0, done = 0. Internally pc = 0 and count = 0.
- start sampled high at edge N: state is RUN after edge N. First push at edge N+1. instr_valid rises after N+1 with instr_pc = 0.
- Throughput is 1 word/cycle while instr_ready is held high.
- When instr_ready is low, the head is stable: instruction and instr_pc do not change until popped.
- The buffer fills to 2 after at most 2 stalled cycles. Fetch then pauses, and pc holds.
- Loads take effect at the edge. A word written at edge M is fetchable by a start at edge M or later.

## Configuration
- FETCH_LOOP_EN defined: after a push from pc == PROG_DEPTH-1, pc wraps to 0 and the state stays in RUN. Only HALT or flush ends the run.
- FETCH_LOOP_EN undefined: a push from pc == PROG_DEPTH-1 moves RUN -> DRAIN, so the last word is delivered and then done asserts.

## Structure
- Package fetch_pkg contains:
  - INSTR_W = 16
  - OPC_HALT = 4'hF
  - the fetch_state_t enum (IDLE/RUN/DRAIN/DONE)
  - the opcode field slice positions [15:12], shared with the Decode stage.
- Sub-module fetch_fifo2: the 2-entry buffer with {data, pc} per entry, push/pop/flush, and count[1:0]. The top level holds pc, the program store, the FSM and the load port.

## Test plan
- Reset with rst low mid-RUN while instr_valid = 1 -> all outputs 0 immediately (asynchronous), state IDLE. The store contents survive.
- Load mem[0..3] = 16'h1123, 16'h2045, 16'h3001, 16'hF000; start; instr_ready held at 1 -> the words come out on consecutive cycles with instr_pc 0..3. busy is high throughout. done rises 1 cycle after the HALT pop.
- Same program with instr_ready = 0 for 5 cycles after start -> instr_valid = 1 holding 16'h1123. pc stops at 2 after 2 pushes. Releasing instr_ready gives an in-order stream with no loss or duplicate.
- Full 16-word store with no HALT; FETCH_LOOP_EN undefined -> 16 words (pc 0..15) then done. FETCH_LOOP_EN defined -> word 16 has instr_pc = 0; flush then returns the state to IDLE and drops instr_valid next cycle.
- ld_en with ld_addr = 2, ld_data = 16'hAAAA during RUN -> ignored; a later run delivers 16'h3001 at pc 2. The same write in DONE -> the next run delivers 16'hAAAA.
- flush and start in the same cycle while in DONE -> state IDLE, done = 0, no fetch.
